// File: rtl/asu_riscv_mult_issue.sv
// Issue/sequencing stage in front of the M-extension multiplier: accepts MUL* requests,
// holds operands for the multi-cycle high-word ops and returns the 32-bit result to writeback.
module asu_riscv_mult_issue #(
  parameter int DATA_W     = 32,
  parameter int RD_W       = 5,
  parameter int HI_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_funct3_i,
  input  logic [RD_W-1:0]   req_rd_i,
  input  logic [DATA_W-1:0] req_op_a_i,
  input  logic [DATA_W-1:0] req_op_b_i,
  output logic [1:0]        mul_operator_o,
  output logic [1:0]        mul_signed_mode_o,
  output logic [DATA_W-1:0] mul_op_a_o,
  output logic [DATA_W-1:0] mul_op_b_o,
  input  logic [DATA_W-1:0] mul_result_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [RD_W-1:0]   rsp_rd_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(HI_LATENCY) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HI    = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] op_a_reg, op_a_next;
  logic [DATA_W-1:0] op_b_reg, op_b_next;
  logic [RD_W-1:0]   rd_reg, rd_next;
  logic [1:0]        op_reg, op_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
  logic [RD_W-1:0]   rsp_rd_reg, rsp_rd_next;
  logic              rsp_err_reg, rsp_err_next;

  logic       accept;
  logic [1:0] req_op;
  logic       req_is_hi;
  logic       cnt_is_one;

  // bit0 = op_a signed, bit1 = op_b signed
  function automatic logic [1:0] mode_of(input logic [1:0] op);
    case (op)
      2'b01:   mode_of = 2'b11;
      2'b10:   mode_of = 2'b01;
      default: mode_of = 2'b00;
    endcase
  endfunction

  assign req_ready_o = !flush_i && ((state_reg == S_IDLE) ||
                                    ((state_reg == S_RESP) && rsp_ready_i));
  assign accept      = req_valid_i && req_ready_o;
  // Unsupported funct3 drives the multiplier as a plain MUL so it never leaves its base state
  assign req_op      = req_funct3_i[2] ? 2'b00 : req_funct3_i[1:0];
  assign req_is_hi   = (req_op != 2'b00);
  assign cnt_is_one  = (cnt_reg == CNT_W'(1));

  assign mul_operator_o    = accept ? req_op :
                             ((state_reg == S_HI) || (state_reg == S_DRAIN)) ? op_reg : 2'b00;
  assign mul_signed_mode_o = mode_of(accept ? req_op : op_reg);
  assign mul_op_a_o        = accept ? req_op_a_i : op_a_reg;
  assign mul_op_b_o        = accept ? req_op_b_i : op_b_reg;

  assign rsp_valid_o = (state_reg == S_RESP);
  assign rsp_rd_o    = rsp_rd_reg;
  assign rsp_data_o  = rsp_data_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign busy_o      = (state_reg != S_IDLE);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    op_a_next     = op_a_reg;
    op_b_next     = op_b_reg;
    rd_next       = rd_reg;
    op_next       = op_reg;
    rsp_data_next = rsp_data_reg;
    rsp_rd_next   = rsp_rd_reg;
    rsp_err_next  = rsp_err_reg;

    case (state_reg)
      S_HI: begin
        if (cnt_is_one) begin
          if (flush_i) begin
            state_next = S_IDLE;
          end else begin
            state_next    = S_RESP;
            rsp_data_next = mul_result_i;
            rsp_rd_next   = rd_reg;
            rsp_err_next  = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
          if (flush_i) state_next = S_DRAIN;
        end
      end
      // Operator keeps being driven until the multiplier's pipeline empties
      S_DRAIN: begin
        if (cnt_is_one) state_next = S_IDLE;
        else            cnt_next   = cnt_reg - CNT_W'(1);
      end
      S_RESP: begin
        if (flush_i || rsp_ready_i) state_next = S_IDLE;
      end
      default: ;
    endcase

    // Accept is only possible from IDLE or a completing RESP, so it overrides the above
    if (accept) begin
      op_a_next = req_op_a_i;
      op_b_next = req_op_b_i;
      rd_next   = req_rd_i;
      op_next   = req_op;
      if (req_is_hi) begin
        state_next = S_HI;
        cnt_next   = CNT_W'(HI_LATENCY - 1);
      end else begin
        state_next    = S_RESP;
        rsp_data_next = req_funct3_i[2] ? '0 : mul_result_i;
        rsp_rd_next   = req_rd_i;
        rsp_err_next  = req_funct3_i[2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      rd_reg       <= '0;
      op_reg       <= 2'b00;
      rsp_data_reg <= '0;
      rsp_rd_reg   <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      op_a_reg     <= op_a_next;
      op_b_reg     <= op_b_next;
      rd_reg       <= rd_next;
      op_reg       <= op_next;
      rsp_data_reg <= rsp_data_next;
      rsp_rd_reg   <= rsp_rd_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

endmodule

// File: tb/tb_asu_riscv_mult_issue.sv
// Bench for asu_riscv_mult_issue with a behavioural multi-cycle multiplier attached.
module tb_asu_riscv_mult_issue;

  localparam int DATA_W     = 32;
  localparam int RD_W       = 5;
  localparam int HI_LATENCY = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [2:0]        req_funct3_i;
  logic [RD_W-1:0]   req_rd_i;
  logic [DATA_W-1:0] req_op_a_i;
  logic [DATA_W-1:0] req_op_b_i;
  logic [1:0]        mul_operator_o;
  logic [1:0]        mul_signed_mode_o;
  logic [DATA_W-1:0] mul_op_a_o;
  logic [DATA_W-1:0] mul_op_b_o;
  logic [DATA_W-1:0] mul_result_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [RD_W-1:0]   rsp_rd_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_err_o;
  logic              busy_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  asu_riscv_mult_issue #(
    .DATA_W(DATA_W), .RD_W(RD_W), .HI_LATENCY(HI_LATENCY)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_funct3_i(req_funct3_i), .req_rd_i(req_rd_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
    .mul_operator_o(mul_operator_o), .mul_signed_mode_o(mul_signed_mode_o),
    .mul_op_a_o(mul_op_a_o), .mul_op_b_o(mul_op_b_o), .mul_result_i(mul_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rd_o(rsp_rd_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o)
  );

  // Multiplier model: low product is combinational; the high word is only valid once the
  // operator has been held for HI_LATENCY-1 cycles, garbage before that.
  int unsigned held;
  always @(posedge clk or posedge rst) begin
    if (rst)                        held <= 0;
    else if (mul_operator_o == 2'b00) held <= 0;
    else                            held <= held + 1;
  end

  logic [63:0] m_ax, m_bx, m_p;
  always_comb begin
    m_ax = mul_signed_mode_o[0] ? {{32{mul_op_a_o[31]}}, mul_op_a_o} : {32'h0, mul_op_a_o};
    m_bx = mul_signed_mode_o[1] ? {{32{mul_op_b_o[31]}}, mul_op_b_o} : {32'h0, mul_op_b_o};
    m_p  = m_ax * m_bx;
    if (mul_operator_o == 2'b00)       mul_result_i = m_p[31:0];
    else if (held >= HI_LATENCY - 1)   mul_result_i = m_p[63:32];
    else                               mul_result_i = 32'hDEADBEEF;
  end

  // Reference: RISC-V M semantics straight from funct3
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ax, bx, p;
    ax = {32'h0, a};
    bx = {32'h0, b};
    if (f3 == 3'b001 || f3 == 3'b010) ax = {{32{a[31]}}, a};
    if (f3 == 3'b001)                 bx = {{32{b[31]}}, b};
    p = ax * bx;
    if (f3[2])            return 32'h0;
    else if (f3 == 3'b000) return p[31:0];
    else                  return p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i      = 1'b0;
    req_valid_i  = 1'b0;
    req_funct3_i = 3'b000;
    req_rd_i     = '0;
    req_op_a_i   = '0;
    req_op_b_i   = '0;
    rsp_ready_i  = 1'b0;
  endtask

  // One full transaction: accept, wait out the latency, hold the response `hold` cycles, retire.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [RD_W-1:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [1:0]  exp_op;
    logic [1:0]  exp_mode;
    logic [31:0] exp_data;
    int          lat;
    exp_op   = f3[2] ? 2'b00 : f3[1:0];
    exp_mode = (exp_op == 2'b01) ? 2'b11 : (exp_op == 2'b10) ? 2'b01 : 2'b00;
    exp_data = ref_result(f3, a, b);
    lat      = (exp_op == 2'b00) ? 1 : HI_LATENCY;

    req_valid_i = 1'b1; req_funct3_i = f3; req_rd_i = rd;
    req_op_a_i  = a;    req_op_b_i   = b;  rsp_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1 || mul_operator_o !== exp_op || mul_signed_mode_o !== exp_mode ||
        mul_op_a_o !== a || mul_op_b_o !== b) begin
      errors++;
      $display("FAIL %s accept: ready=%b op=%b mode=%b a=%h b=%h, required ready=1 op=%b mode=%b a=%h b=%h",
               name, req_ready_o, mul_operator_o, mul_signed_mode_o, mul_op_a_o, mul_op_b_o,
               exp_op, exp_mode, a, b);
    end
    tick();
    req_valid_i = 1'b0;
    req_op_a_i  = $urandom;
    req_op_b_i  = $urandom;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b1 || mul_operator_o !== exp_op ||
          mul_op_a_o !== a || mul_op_b_o !== b) begin
        errors++;
        $display("FAIL %s hi cycle %0d: valid=%b busy=%b op=%b a=%h b=%h, required valid=0 busy=1 op=%b a=%h b=%h",
                 name, k, rsp_valid_o, busy_o, mul_operator_o, mul_op_a_o, mul_op_b_o, exp_op, a, b);
      end
      tick();
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== exp_data || rsp_rd_o !== rd ||
          rsp_err_o !== f3[2] || mul_operator_o !== 2'b00) begin
        errors++;
        $display("FAIL %s rsp hold %0d: valid=%b data=%h rd=%0d err=%b op=%b, required valid=1 data=%h rd=%0d err=%b op=00",
                 name, h, rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_err_o, mul_operator_o,
                 exp_data, rd, f3[2]);
      end
      if (h == hold) rsp_ready_i = 1'b1;
      tick();
    end
    rsp_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s retire: valid=%b busy=%b, required valid=0 busy=0", name, rsp_valid_o, busy_o);
    end
    $display("txn %s f3=%b rd=%0d a=%h b=%h -> data=%h err=%b", name, f3, rd, a, b, rsp_data_o, rsp_err_o);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || busy_o !== 1'b0 || rsp_data_o !== 32'h0 ||
        rsp_rd_o !== 5'd0 || mul_operator_o !== 2'b00 || mul_op_a_o !== 32'h0) begin
      errors++;
      $display("FAIL reset: valid=%b err=%b busy=%b data=%h rd=%0d op=%b a=%h, required all zero",
               rsp_valid_o, rsp_err_o, busy_o, rsp_data_o, rsp_rd_o, mul_operator_o, mul_op_a_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_op("mul_7x6", 3'b000, 5'd1, 32'd7, 32'd6, 0);
    run_op("mulhu_max", 3'b011, 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("mulh_m1x2", 3'b001, 5'd3, 32'hFFFFFFFF, 32'd2, 1);
    run_op("mulhsu_max", 3'b010, 5'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("unsup_100", 3'b100, 5'd9, 32'd3, 32'd4, 0);
    run_op("unsup_111", 3'b111, 5'd30, 32'h12345678, 32'h9ABCDEF0, 1);
  endtask

  task automatic test_back_to_back();
    req_valid_i = 1'b1; req_funct3_i = 3'b000; req_rd_i = 5'd5;
    req_op_a_i  = 32'd3; req_op_b_i  = 32'd5; rsp_ready_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'd15 || rsp_rd_o !== 5'd5 || req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL b2b stall %0d: valid=%b data=%0d rd=%0d ready=%b, required valid=1 data=15 rd=5 ready=0",
                 h, rsp_valid_o, rsp_data_o, rsp_rd_o, req_ready_o);
      end
      tick();
    end
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_rd_i = 5'd6; req_op_a_i = 32'd2; req_op_b_i = 32'd2;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1 || rsp_data_o !== 32'd15) begin
      errors++;
      $display("FAIL b2b overlap: ready=%b data=%0d, required ready=1 data=15", req_ready_o, rsp_data_o);
    end
    tick();
    req_valid_i = 1'b0; rsp_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'd4 || rsp_rd_o !== 5'd6) begin
      errors++;
      $display("FAIL b2b second: valid=%b data=%0d rd=%0d, required valid=1 data=4 rd=6",
               rsp_valid_o, rsp_data_o, rsp_rd_o);
    end
    $display("txn b2b 3*5 then 2*2 -> data=%0d", rsp_data_o);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    req_valid_i = 1'b1; req_funct3_i = 3'b001; req_rd_i = 5'd7;
    req_op_a_i  = 32'h80000000; req_op_b_i = 32'h7FFFFFFF;
    tick();
    // flush in HI while a new request is offered: it must be refused
    flush_i = 1'b1; req_funct3_i = 3'b000;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL flush ready: ready=%b, required 0", req_ready_o);
    end
    tick();
    flush_i = 1'b0; req_valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || mul_operator_o !== 2'b00) begin
        errors++;
        $display("FAIL flush hi cycle %0d: valid=%b busy=%b op=%b, required 0 0 00",
                 k, rsp_valid_o, busy_o, mul_operator_o);
      end
      tick();
    end
    $display("txn flush_in_hi mulh killed");
    run_op("mul_9x9", 3'b000, 5'd8, 32'd9, 32'd9, 0);
    // flush while a response is stalled
    req_valid_i = 1'b1; req_funct3_i = 3'b000; req_rd_i = 5'd2;
    req_op_a_i  = 32'd11; req_op_b_i = 32'd11;
    tick();
    req_valid_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush resp: valid=%b busy=%b, required 0 0", rsp_valid_o, busy_o);
    end
    $display("txn flush_in_resp mul killed");
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h80000000;
      if ($urandom_range(0, 3) == 0) b = 32'hFFFFFFFF;
      run_op($sformatf("rand%0d", n), f3, 5'($urandom), a, b, $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_op();
    req_valid_i = 1'b1; req_funct3_i = 3'b011; req_rd_i = 5'd21;
    req_op_a_i  = 32'hCAFEF00D; req_op_b_i = 32'h12345678;
    tick();
    req_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || busy_o !== 1'b0 || rsp_data_o !== 32'h0 ||
        rsp_rd_o !== 5'd0 || mul_operator_o !== 2'b00 || mul_op_a_o !== 32'h0 || mul_op_b_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_op: valid=%b err=%b busy=%b data=%h rd=%0d op=%b a=%h b=%h, required all zero",
               rsp_valid_o, rsp_err_o, busy_o, rsp_data_o, rsp_rd_o, mul_operator_o, mul_op_a_o, mul_op_b_o);
    end
    $display("txn reset_mid_op");
    tick();
    rst = 1'b0;
    tick();
    run_op("post_reset", 3'b000, 5'd12, 32'd100, 32'd100, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
